irq_timer: RTL and testbench
============================

# irq_timer

Memory-mapped countdown timer that originates hardware interrupt requests. It sits on the system bridge, is programmed by the processor with `sw` and read with `lw`, and drives one `irq` line into the coprocessor's interrupt input vector. The coprocessor samples that vector into Cause every cycle and gates it with the SR mask. Mode 0 gives a one-shot, level-held interrupt. Mode 1 gives a periodic, single-cycle pulse with automatic reload.

## Interface
- `PRESC_W`, default 16: width of the prescale register. Used only when the prescaler is compiled in.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `addr`  in  2: word offset, from byte address bits [3:2]. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = PRESC.
- `we`  in  1: bus write strobe. Registers update on the edge where it is sampled high.
- `wd`  in  32: bus write data.
- `rd`  out  32: combinational read of the register selected by `addr`.
- `irq`  out  1: interrupt request to the coprocessor. Registered.

## Operation
- CTRL fields:
  - bit0 `en`: count enable.
  - bits[2:1] `mode`: 00 = one-shot, 01 = periodic. 10 and 11 behave as 00.
  - bit3 `im`: interrupt mask.
  - All other bits are written as don't-care and read as 0.
- PRESET: full 32-bit reload value.
- COUNT: read-only. Writes to it are ignored.
- `irq` = `irq_pend` & `im`.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE → LOAD when `en` = 1.
  - LOAD:
    - count ← PRESET.
    - → INT if PRESET = 0, else → CNT.
  - CNT:
    - `en` = 0 → IDLE, COUNT holds its value.
    - Otherwise, on each tick: count ← count − 1.
    - On the tick where count = 1: count ← 0 and → INT.
  - INT, mode 0: `en` ← 0, → IDLE.
  - INT, mode 1: → LOAD.
- `irq_pend`:
  - Set on the edge that enters INT.
  - Mode 1: cleared on the edge that leaves INT, giving exactly a 1-cycle pulse.
  - Mode 0: held until any bus write to CTRL or PRESET.
- A PRESET write during CNT does not change COUNT. It takes effect at the next LOAD.
- A bus write to CTRL in the same cycle as the INT-state hardware clear of `en` wins. The written `en` is kept.
- COUNT never wraps below 0.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, PRESC = 0, state = IDLE, `irq_pend` = 0.
  - Hence `irq` = 0 and `rd` = 0 for every `addr`.
- Reset mid-count: on the reset edge, all registers return to the values above and any pending `irq` drops.
- Start latency, with `en` written on edge E0:
  - E0+1: LOAD.
  - E0+2: COUNT = PRESET, state = CNT.
  - First decrement at E0+3.
- For PRESET = N ≥ 1 and 1 tick per cycle, `irq` rises after edge E0+N+2. For N = 0 it rises after E0+2.
- Periodic mode: period = N+2 cycles. Each cycle is N decrements, 1 INT and 1 LOAD.
- `rd` reflects a register write on the cycle after the write edge.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - PRESC (offset 3, low `PRESC_W` bits) is implemented.
  - CNT decrements once every PRESC+1 clocks.
  - The divider counter clears in LOAD and while not in CNT.
- `TIMER_PRESCALE_EN` undefined:
  - Offset 3 reads 0 and writes to it are ignored.
  - The tick is asserted every cycle.

## Structure
- Package `timer_pkg` holds:
  - FSM state encoding (IDLE = 0, LOAD = 1, CNT = 2, INT = 3).
  - Register offset constants.
  - CTRL bit positions.
  - Mode constants.
- One sub-module, `timer_prescaler`: the tick divider. It is instantiated only under `TIMER_PRESCALE_EN`.

## Test plan
- Reset, then read all four offsets → every read is 0 and `irq` = 0.
- PRESET = 3, then CTRL = 0x9 (`en`, mode 0, `im`) on E0:
  - COUNT reads 3, 2, 1, 0 after E0+2 … E0+5.
  - `irq` = 1 from E0+5 and stays high; CTRL reads 0x8.
  - A subsequent write of CTRL = 0x8 drops `irq` next cycle.
- PRESET = 2, CTRL = 0xB (periodic): `irq` is a 1-cycle pulse every 4 cycles, repeated for 3 periods.
- Edge cases:
  - PRESET = 0 with mode 0 → `irq` after E0+2.
  - CTRL = 0x1 (`im` = 0) → `irq` stays 0 while COUNT reaches 0 and `en` self-clears.
- Counting from PRESET = 10, write CTRL = 0x8 when COUNT = 6 → COUNT holds 6 and state returns to IDLE. Writing CTRL = 0x9 then restarts from the PRESET reload.
- `TIMER_PRESCALE_EN` with PRESC = 2, PRESET = 2 → decrements 3 clocks apart, `irq` after E0+2+6.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared constants for irq_timer: FSM encoding, register offsets,
//            CTRL bit positions and mode values.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_PRESC  = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : timer_prescaler
// Purpose  : Tick divider for irq_timer; tick asserts once every presc+1 clocks.
// Revision : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_div <= '0;
        end else if (tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + PRESC_W'(1);
        end
    end

    assign tick = (r_div == presc);

endmodule
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
// Module   : irq_timer
// Purpose  : Memory-mapped countdown timer with one-shot (level) and periodic
//            (pulse) interrupt modes. Optional prescaler: TIMER_PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module irq_timer
    import timer_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_en;
    logic [1:0]         r_mode;
    logic               r_im;
    logic [31:0]        r_preset;
    logic [31:0]        r_count;
    logic               r_irq_pend;

    logic               w_tick;
    logic               w_periodic;
    logic               w_ctrl_wr;
    logic               w_preset_wr;
    logic               w_load;
    logic               w_dec;
    logic               w_en_clr;
    logic               w_pend_set;
    logic               w_pend_end;
    logic [PRESC_W-1:0] w_presc_rd;

    assign w_ctrl_wr   = we && (addr == ADDR_CTRL);
    assign w_preset_wr = we && (addr == ADDR_PRESET);
    assign w_periodic  = (r_mode == MODE_PERIODIC);

`ifdef TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] r_presc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (we && (addr == ADDR_PRESC)) begin
            r_presc <= wd[PRESC_W-1:0];
        end
    end

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (reset),
        .clear (r_state != S_CNT),
        .presc (r_presc),
        .tick  (w_tick)
    );

    assign w_presc_rd = r_presc;
`else
    assign w_tick     = 1'b1;
    assign w_presc_rd = '0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (r_en) w_state_next = S_LOAD;
            S_LOAD: w_state_next = (r_preset == 32'd0) ? S_INT : S_CNT;
            S_CNT: begin
                if (!r_en) begin
                    w_state_next = S_IDLE;
                end else if (w_tick && (r_count <= 32'd1)) begin
                    w_state_next = S_INT;
                end
            end
            S_INT:   w_state_next = w_periodic ? S_LOAD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_en_clr   = 1'b0;
        w_pend_end = 1'b0;
        case (r_state)
            S_LOAD: w_load = 1'b1;
            S_CNT:  w_dec  = r_en && w_tick;
            S_INT: begin
                w_en_clr   = !w_periodic;
                w_pend_end = w_periodic;
            end
            default: ;
        endcase
    end

    assign w_pend_set = (w_state_next == S_INT) && (r_state != S_INT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_mode     <= MODE_ONESHOT;
            r_im       <= 1'b0;
            r_preset   <= 32'd0;
            r_count    <= 32'd0;
            r_irq_pend <= 1'b0;
        end else begin
            // A bus write to CTRL overrides the one-shot self-clear of en.
            if (w_ctrl_wr) begin
                r_en   <= wd[CTRL_EN_BIT];
                r_mode <= wd[CTRL_MODE_MSB:CTRL_MODE_LSB];
                r_im   <= wd[CTRL_IM_BIT];
            end else if (w_en_clr) begin
                r_en <= 1'b0;
            end

            if (w_preset_wr) begin
                r_preset <= wd;
            end

            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= (r_count > 32'd1) ? (r_count - 32'd1) : 32'd0;
            end

            if (w_pend_set) begin
                r_irq_pend <= 1'b1;
            end else if (w_pend_end || w_ctrl_wr || w_preset_wr) begin
                r_irq_pend <= 1'b0;
            end
        end
    end

    assign irq = r_irq_pend & r_im;

    always_comb begin
        rd = 32'd0;
        case (addr)
            ADDR_CTRL:   rd = {28'd0, r_im, r_mode, r_en};
            ADDR_PRESET: rd = r_preset;
            ADDR_COUNT:  rd = r_count;
            ADDR_PRESC:  rd = 32'(w_presc_rd);
            default:     rd = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_timer
// Purpose  : Directed self-checking bench for irq_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_timer;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_PRESC  = 2'd3;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int n_checks;
    int n_errors;

    irq_timer #(
        .PRESC_W (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rd, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        we    = 1'b0;
        addr  = A_CTRL;
        wd    = 32'd0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        chk_rd("rst_ctrl",   A_CTRL,   32'd0);
        chk_rd("rst_preset", A_PRESET, 32'd0);
        chk_rd("rst_count",  A_COUNT,  32'd0);
        chk_rd("rst_presc",  A_PRESC,  32'd0);
        chk_irq("rst_irq", 1'b0);

        // One-shot, PRESET = 3
        wr(A_PRESET, 32'd3);
        chk_rd("os_preset", A_PRESET, 32'd3);
        wr(A_CTRL, 32'h9);
        chk_rd("os_ctrl_e0", A_CTRL, 32'h9);
        step(1);
        for (int k = 2; k <= 5; k++) begin
            step(1);
            chk_rd($sformatf("os_count_e%0d", k), A_COUNT, 32'(5 - k));
            chk_irq($sformatf("os_irq_e%0d", k), k == 5);
        end
        step(1);
        chk_rd("os_ctrl_selfclr", A_CTRL, 32'h8);
        chk_irq("os_irq_held1", 1'b1);
        step(3);
        chk_irq("os_irq_held2", 1'b1);
        chk_rd("os_count_floor", A_COUNT, 32'd0);
        wr(A_CTRL, 32'h8);
        chk_irq("os_irq_cleared", 1'b0);

        // COUNT is read-only
        wr(A_COUNT, 32'h55);
        chk_rd("count_ro", A_COUNT, 32'd0);

        // Periodic, PRESET = 2: 1-cycle pulse every 4 cycles
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 13; k++) begin
            step(1);
            chk_irq($sformatf("per_irq_e%0d", k), (k >= 4) && (((k - 4) % 4) == 0));
        end
        wr(A_CTRL, 32'h0);
        step(2);
        chk_irq("per_stopped", 1'b0);

        // PRESET = 0 one-shot, plus CTRL write colliding with the INT self-clear
        wr(A_PRESET, 32'd0);
        wr(A_CTRL, 32'h9);
        step(1);
        chk_irq("p0_irq_e1", 1'b0);
        step(1);
        chk_irq("p0_irq_e2", 1'b1);
        wr(A_CTRL, 32'h9);
        chk_rd("p0_ctrl_write_wins", A_CTRL, 32'h9);
        chk_irq("p0_irq_cleared", 1'b0);
        step(1);
        chk_irq("p0_irq_e4", 1'b0);
        step(1);
        chk_irq("p0_irq_e5", 1'b1);
        wr(A_CTRL, 32'h0);
        chk_irq("p0_stop", 1'b0);
        step(2);

        // Masked: im = 0
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk_irq($sformatf("mask_irq_e%0d", k), 1'b0);
        end
        chk_rd("mask_count", A_COUNT, 32'd0);
        chk_rd("mask_ctrl_selfclr", A_CTRL, 32'h0);

        // Hold at COUNT = 6 from PRESET = 10, then restart
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        step(5);
        chk_rd("hold_count7", A_COUNT, 32'd7);
        wr(A_CTRL, 32'h8);
        chk_rd("hold_count6", A_COUNT, 32'd6);
        step(4);
        chk_rd("hold_count_kept", A_COUNT, 32'd6);
        chk_rd("hold_ctrl", A_CTRL, 32'h8);
        chk_irq("hold_irq", 1'b0);
        wr(A_CTRL, 32'h9);
        step(1);
        chk_rd("restart_e1", A_COUNT, 32'd6);
        step(1);
        chk_rd("restart_e2", A_COUNT, 32'd10);
        step(1);
        chk_rd("restart_e3", A_COUNT, 32'd9);
        wr(A_CTRL, 32'h0);
        step(2);

        // Reset mid-count drops everything
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_rd("mrst_ctrl",   A_CTRL,   32'd0);
        chk_rd("mrst_preset", A_PRESET, 32'd0);
        chk_rd("mrst_count",  A_COUNT,  32'd0);
        chk_irq("mrst_irq", 1'b0);
        step(4);
        chk_rd("mrst_idle_count", A_COUNT, 32'd0);

`ifdef TIMER_PRESCALE_EN
        // PRESC = 2, PRESET = 2: decrements 3 clocks apart
        wr(A_PRESC, 32'd2);
        chk_rd("psc_reg", A_PRESC, 32'd2);
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk_irq($sformatf("psc_irq_e%0d", k), k >= 8);
            if (k >= 2) begin
                chk_rd($sformatf("psc_count_e%0d", k), A_COUNT,
                       (k < 5) ? 32'd2 : ((k < 8) ? 32'd1 : 32'd0));
            end
        end
        wr(A_CTRL, 32'h0);
`else
        wr(A_PRESC, 32'd2);
        chk_rd("presc_absent", A_PRESC, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
